// File: rtl/dl_sequencer.sv
// ---------------------------------------------------------------------------
// dl_sequencer
//
// This block decodes the HPS download stream for the vector-arcade core and
// routes each byte to its destination.
// - ROM bytes (index 0) are queued in a small FIFO. The FIFO drives the shared
//   ROM write port through a valid/ready handshake.
// - The game selector byte (index 1) and the two DIP banks (index 254) are
//   latched into registers.
// - The CPU is held in reset until the download ends, the FIFO drains, and a
//   settle interval has elapsed.
//
// Ports
//   clk_i        system clock, rising edge
//   btnCpuReset  asynchronous active-low reset
//   dl_download  download in progress
//   dl_wr        one-cycle byte strobe
//   dl_index     download index
//   dl_addr      byte address within the index
//   dl_data      byte value
//   mem_valid    ROM write request (FIFO non-empty)
//   mem_ready    ROM port accepts the current request
//   mem_addr     ROM write address (FIFO head)
//   mem_region   ROM region select (FIFO head)
//   mem_data     ROM write data (FIFO head)
//   mod_o        game selector
//   dsw0_o       DIP bank 0
//   dsw1_o       DIP bank 1
//   cpu_run_o    release the CPU from reset
//   busy_o       sequencer not in RUN
//   overflow_o   sticky: a ROM byte was dropped
// ---------------------------------------------------------------------------
module dl_sequencer #(
   parameter int SETTLE_CYCLES = 1024,
   parameter int FIFO_DEPTH    = 4,
   parameter int ADDR_W        = 14
) (
   input  logic              clk_i,
   input  logic              btnCpuReset,
   input  logic              dl_download,
   input  logic              dl_wr,
   input  logic [7:0]        dl_index,
   input  logic [24:0]       dl_addr,
   input  logic [7:0]        dl_data,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_region,
   output logic [7:0]        mem_data,
   output logic [7:0]        mod_o,
   output logic [7:0]        dsw0_o,
   output logic [7:0]        dsw1_o,
   output logic              cpu_run_o,
   output logic              busy_o,
   output logic              overflow_o
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = 2 + ADDR_W + 8;
   localparam logic [PTR_W:0] FULL_FILL = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   localparam logic [1:0] ST_SETTLE = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_LOAD   = 2'd2;
   localparam logic [1:0] ST_DRAIN  = 2'd3;

   // Byte decode
   logic rom_byte;

   // Only the two region bits above the ROM address may be set; anything
   // higher lies outside the ROM space and is ignored.
   assign rom_byte = dl_wr && (dl_index == 8'd0)
                     && ((dl_addr >> (ADDR_W + 2)) == 25'd0);

   // ROM write FIFO
   logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   fill;
   logic             empty;
   logic             full;
   logic             pop;
   logic             push;
   logic [ENT_W-1:0] head;

   assign empty = (fill == '0);
   assign full  = (fill == FULL_FILL);
   assign pop   = !empty && mem_ready;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign push  = rom_byte && (!full || pop);

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {dl_addr[ADDR_W+1:ADDR_W], dl_addr[ADDR_W-1:0], dl_data};
      end
   end

   always_ff @(posedge clk_i or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   // The storage is not reset. The port fields are therefore forced to zero
   // while the FIFO is empty, which gives the reset values without clearing
   // the array.
   assign head       = fifo_mem[rd_ptr];
   assign mem_valid  = !empty;
   assign mem_region = empty ? 2'd0 : head[ENT_W-1:ENT_W-2];
   assign mem_addr   = empty ? '0   : head[ADDR_W+7:8];
   assign mem_data   = empty ? 8'd0 : head[7:0];

   // Overflow flag, re-armed on each new download
   logic dl_prev;

   always_ff @(posedge clk_i or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         dl_prev    <= 1'b0;
         overflow_o <= 1'b0;
      end else begin
         dl_prev <= dl_download;
         if (dl_download && !dl_prev) overflow_o <= 1'b0;
         // A drop in the re-arm cycle still counts.
         if (rom_byte && !push)       overflow_o <= 1'b1;
      end
   end

   // Latched configuration bytes
   always_ff @(posedge clk_i or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         mod_o  <= 8'hFF;
         dsw0_o <= 8'h00;
         dsw1_o <= 8'h00;
      end else if (dl_wr) begin
         if (dl_index == 8'd1) mod_o <= dl_data;
         if (dl_index == 8'd254 && dl_addr == 25'd0) dsw0_o <= dl_data;
         if (dl_index == 8'd254 && dl_addr == 25'd1) dsw1_o <= dl_data;
      end
   end

   // CPU hold sequencer
   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_i or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         state <= ST_SETTLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (dl_download) state <= ST_LOAD;
            end
            ST_LOAD: begin
               if (!dl_download) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (dl_download) begin
                  state <= ST_LOAD;
                  cnt   <= '0;
               end else if (empty && !rom_byte) begin
                  state <= ST_SETTLE;
                  cnt   <= '0;
               end
            end
            default: begin
               if (dl_download) begin
                  state <= ST_LOAD;
                  cnt   <= '0;
               end else if (cnt == SETTLE_LAST) begin
                  state <= ST_RUN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign cpu_run_o = (state == ST_RUN);
   assign busy_o    = !cpu_run_o;

endmodule

// File: tb/tb_dl_sequencer.sv
module tb_dl_sequencer;
   localparam int S  = 16;
   localparam int D  = 4;
   localparam int AW = 14;

   logic          clk = 1'b0;
   logic          btnCpuReset;
   logic          dl_download;
   logic          dl_wr;
   logic [7:0]    dl_index;
   logic [24:0]   dl_addr;
   logic [7:0]    dl_data;
   logic          mem_valid;
   logic          mem_ready;
   logic [AW-1:0] mem_addr;
   logic [1:0]    mem_region;
   logic [7:0]    mem_data;
   logic [7:0]    mod_o;
   logic [7:0]    dsw0_o;
   logic [7:0]    dsw1_o;
   logic          cpu_run_o;
   logic          busy_o;
   logic          overflow_o;

   always #5 clk = ~clk;

   dl_sequencer #(.SETTLE_CYCLES(S), .FIFO_DEPTH(D), .ADDR_W(AW)) dut (
      .clk_i(clk), .btnCpuReset(btnCpuReset), .dl_download(dl_download),
      .dl_wr(dl_wr), .dl_index(dl_index), .dl_addr(dl_addr), .dl_data(dl_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_region(mem_region), .mem_data(mem_data), .mod_o(mod_o),
      .dsw0_o(dsw0_o), .dsw1_o(dsw1_o), .cpu_run_o(cpu_run_o),
      .busy_o(busy_o), .overflow_o(overflow_o)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model
   logic [23:0] q[$];
   bit          m_ovf;
   logic [7:0]  m_mod, m_dsw0, m_dsw1;
   bit          m_dl_prev;
   bit          m_drain_pending;
   int          m_release_at;
   int          cyc = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      m_ovf           = 1'b0;
      m_mod           = 8'hFF;
      m_dsw0          = 8'h00;
      m_dsw1          = 8'h00;
      m_dl_prev       = 1'b0;
      m_drain_pending = 1'b0;
      m_release_at    = cyc + S;
   endfunction

   function automatic void model_edge();
      bit push_req, pop, acc;
      int n;
      cyc++;
      n        = q.size();
      push_req = dl_wr && dl_index == 8'd0 && dl_addr < 25'h10000;
      pop      = (n > 0) && mem_ready;
      acc      = push_req && ((n < D) || pop);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back({dl_addr[15:14], dl_addr[13:0], dl_data});
      if (dl_download && !m_dl_prev) m_ovf = 1'b0;
      if (push_req && !acc) m_ovf = 1'b1;
      if (dl_wr) begin
         if (dl_index == 8'd1) m_mod = dl_data;
         if (dl_index == 8'd254 && dl_addr == 25'd0) m_dsw0 = dl_data;
         if (dl_index == 8'd254 && dl_addr == 25'd1) m_dsw1 = dl_data;
      end
      // The CPU is held from the first download cycle until it has been low for
      // more than one cycle and the queue is idle. It is released S clocks later.
      if (dl_download) begin
         m_release_at    = -1;
         m_drain_pending = 1'b1;
      end else if (m_drain_pending && !m_dl_prev && n == 0 && !push_req) begin
         m_drain_pending = 1'b0;
         m_release_at    = cyc + S;
      end
      m_dl_prev = dl_download;
   endfunction

   task automatic compare_all();
      logic [23:0] h;
      bit exp_run;
      exp_run = (m_release_at >= 0) && (cyc >= m_release_at);
      check_val("mem_valid", mem_valid, q.size() > 0);
      if (q.size() > 0) begin
         h = q[0];
         check_val("mem_region", mem_region, h[23:22]);
         check_val("mem_addr", mem_addr, h[21:8]);
         check_val("mem_data", mem_data, h[7:0]);
      end
      check_val("mod_o", mod_o, m_mod);
      check_val("dsw0_o", dsw0_o, m_dsw0);
      check_val("dsw1_o", dsw1_o, m_dsw1);
      check_val("overflow_o", overflow_o, m_ovf);
      check_val("cpu_run_o", cpu_run_o, exp_run);
      check_val("busy_o", busy_o, !exp_run);
   endtask

   task automatic step(input bit dl, input bit wr, input logic [7:0] idx,
                       input logic [24:0] addr, input logic [7:0] data, input bit rdy);
      dl_download = dl;
      dl_wr       = wr;
      dl_index    = idx;
      dl_addr     = addr;
      dl_data     = data;
      mem_ready   = rdy;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle(input int n, input bit dl, input bit rdy);
      for (int i = 0; i < n; i++) step(dl, 1'b0, 8'd0, 25'd0, 8'd0, rdy);
   endtask

   task automatic check_reset_values(input string tag);
      check_val({tag, "_mem_valid"}, mem_valid, 1'b0);
      check_val({tag, "_mem_addr"}, mem_addr, 14'd0);
      check_val({tag, "_mem_region"}, mem_region, 2'd0);
      check_val({tag, "_mem_data"}, mem_data, 8'd0);
      check_val({tag, "_mod"}, mod_o, 8'hFF);
      check_val({tag, "_dsw0"}, dsw0_o, 8'h00);
      check_val({tag, "_dsw1"}, dsw1_o, 8'h00);
      check_val({tag, "_cpu_run"}, cpu_run_o, 1'b0);
      check_val({tag, "_busy"}, busy_o, 1'b1);
      check_val({tag, "_overflow"}, overflow_o, 1'b0);
   endtask

   initial begin
      bit          dl;
      int          sel;
      logic [7:0]  idx;
      logic [24:0] a;

      btnCpuReset = 1'b0;
      dl_download = 1'b0;
      dl_wr       = 1'b0;
      dl_index    = 8'd0;
      dl_addr     = 25'd0;
      dl_data     = 8'd0;
      mem_ready   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      btnCpuReset = 1'b1;
      model_reset();
      #1;
      check_reset_values("por");

      // Idle after reset: release exactly S clocks later
      idle(20, 1'b0, 1'b1);

      // Streaming 8 bytes with mem_ready held high, then drain and settle
      step(1'b1, 1'b0, 8'd0, 25'd0, 8'd0, 1'b1);
      for (int i = 0; i < 8; i++)
         step(1'b1, 1'b1, 8'd0, 25'(i), 8'(8'hA0 + i), 1'b1);
      idle(25, 1'b0, 1'b1);

      // Back-pressure: 6 bytes into 4 slots
      step(1'b1, 1'b0, 8'd0, 25'd0, 8'd0, 1'b0);
      for (int i = 0; i < 6; i++)
         step(1'b1, 1'b1, 8'd0, 25'(25'h100 + i), 8'(8'hC0 + i), 1'b0);
      check_val("ovf_set", overflow_o, 1'b1);
      check_val("held_head", mem_data, 8'hC0);
      idle(6, 1'b1, 1'b1);
      step(1'b0, 1'b0, 8'd0, 25'd0, 8'd0, 1'b1);
      idle(2, 1'b0, 1'b1);
      step(1'b1, 1'b0, 8'd0, 25'd0, 8'd0, 1'b1);
      check_val("ovf_clr", overflow_o, 1'b0);

      // Configuration bytes
      step(1'b1, 1'b1, 8'd254, 25'd0, 8'h5A, 1'b1);
      step(1'b1, 1'b1, 8'd254, 25'd1, 8'h3C, 1'b1);
      step(1'b1, 1'b1, 8'd254, 25'd2, 8'h77, 1'b1);
      step(1'b1, 1'b1, 8'd1, 25'd0, 8'h02, 1'b1);
      check_val("dsw0_5a", dsw0_o, 8'h5A);
      check_val("dsw1_3c", dsw1_o, 8'h3C);
      check_val("mod_02", mod_o, 8'h02);

      // Region split and out-of-range address
      step(1'b1, 1'b1, 8'd0, 25'h9005, 8'h11, 1'b0);
      check_val("region_2", mem_region, 2'd2);
      check_val("addr_1005", mem_addr, 14'h1005);
      step(1'b1, 1'b1, 8'd0, 25'h10000, 8'h22, 1'b0);
      step(1'b1, 1'b0, 8'd0, 25'd0, 8'd0, 1'b1);
      check_val("no_push_hi", mem_valid, 1'b0);

      // Reset while 3 bytes are queued
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b1, 8'd0, 25'(i), 8'(8'h30 + i), 1'b0);
      check_val("queued3", mem_valid, 1'b1);
      #2;
      btnCpuReset = 1'b0;
      #1;
      check_reset_values("midrst");
      dl_download = 1'b0;
      dl_wr       = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      btnCpuReset = 1'b1;
      model_reset();
      idle(20, 1'b0, 1'b0);

      // Randomized traffic
      dl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 59) == 0) dl = !dl;
         sel = int'($urandom_range(0, 9));
         if (sel <= 5) begin
            idx = 8'd0;
            a   = (sel == 5) ? 25'($urandom) : 25'($urandom_range(0, 25'h13FFF));
         end else if (sel == 6) begin
            idx = 8'd1;
            a   = 25'($urandom_range(0, 255));
         end else if (sel == 8) begin
            idx = 8'($urandom);
            a   = 25'($urandom_range(0, 3));
         end else begin
            idx = 8'd254;
            a   = 25'($urandom_range(0, 3));
         end
         step(dl, 1'($urandom_range(0, 1)), idx, a, 8'($urandom),
              $urandom_range(0, 9) < 6);
      end
      idle(40, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
